// File: rtl/uart_bridge_pkg.sv
// Shared types, ASCII constants and hex helpers for the UART register bridge.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_WAIT_CR, S_FLUSH, S_EXEC, S_RD_WAIT, S_ERR, S_RESP
  } state_e;

  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_R_LC = 8'h72;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_W_LC = 8'h77;
  localparam logic [7:0] CH_O    = 8'h4F;
  localparam logic [7:0] CH_K    = 8'h4B;
  localparam logic [7:0] CH_E    = 8'h45;

  // Reply buffer: element 0 is transmitted first.
  typedef logic [3:0][7:0] resp_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex2nib(input logic [7:0] c);
    hex_t r;
    r.valid = 1'b1;
    r.nib   = c[3:0];
    if (c >= 8'h30 && c <= 8'h39) r.nib = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) r.nib = c[3:0] + 4'd9;
    else r.valid = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] nib2hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic resp_t make_resp(input logic [7:0] b0, input logic [7:0] b1);
    return {CH_LF, CH_CR, b1, b0};
  endfunction

endpackage

// File: rtl/uart_resp_seq.sv
// Four-byte reply sequencer: holds a loaded reply and pushes it into the tx FIFO
// one byte per cycle, stalling on tx_full without losing or repeating a byte.
module uart_resp_seq
  import uart_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  resp_t      load_data_i,
  input  logic       tx_full_i,
  output logic       tx_push_o,
  output logic [7:0] tx_push_data_o,
  output logic       done_o
);

  resp_t      rbuf_q, rbuf_d;
  logic [1:0] idx_q, idx_d;
  logic       active_q, active_d;
  logic       push;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rbuf_d   = rbuf_q;
    idx_d    = idx_q;
    active_d = active_q;
    push     = active_q && !tx_full_i;
    if (load_i) begin
      rbuf_d   = load_data_i;
      idx_d    = 2'd0;
      active_d = 1'b1;
    end else if (push) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the reply buffer is reset too, so tx_push_data reads 0 while in reset.
      rbuf_q   <= '0;
      idx_q    <= 2'd0;
      active_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      rbuf_q   <= rbuf_d;
      idx_q    <= idx_d;
      active_q <= active_d;
    end
  end

  assign tx_push_o      = push;
  assign tx_push_data_o = rbuf_q[idx_q];
  assign done_o         = push && (idx_q == 2'd3);

endmodule

// File: rtl/uart_reg_bridge.sv
// ASCII command parser between the UART FIFOs and an 8-bit register bus:
// "R<aa>\r" reads, "W<aa><dd>\r" writes, replies "<dd>\r\n", "OK\r\n" or "ER\r\n".
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_pop_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_push_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       cmd_err
);

  import uart_bridge_pkg::*;

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [2:0]  nib_q, nib_d;
  logic [15:0] sh_q, sh_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pop;
  logic        resp_load;
  logic        resp_done;
  resp_t       resp_data;
  hex_t        hx;

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    nib_d     = nib_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = '0;
    pop       = 1'b0;
    resp_load = 1'b0;
    resp_data = make_resp(CH_E, CH_R);
    hx        = hex2nib(rx_pop_data);

    case (state_q)
      S_IDLE: if (!rx_empty) begin
        pop = 1'b1;
        if (rx_pop_data == CH_R || rx_pop_data == CH_R_LC) begin
          is_wr_d = 1'b0;
          nib_d   = 3'd2;
          state_d = S_ARG;
        end else if (rx_pop_data == CH_W || rx_pop_data == CH_W_LC) begin
          is_wr_d = 1'b1;
          nib_d   = 3'd4;
          state_d = S_ARG;
        end else if (rx_pop_data != CH_CR && rx_pop_data != CH_LF && rx_pop_data != CH_SP) begin
          state_d = S_FLUSH;
        end
      end
      S_ARG: if (!rx_empty) begin
        pop = 1'b1;
        if (rx_pop_data == CH_CR) state_d = S_ERR;
        else if (!hx.valid) state_d = S_FLUSH;
        else begin
          sh_d  = {sh_q[11:0], hx.nib};
          nib_d = nib_q - 3'd1;
          if (nib_q == 3'd1) state_d = S_WAIT_CR;
        end
      end
      S_WAIT_CR: if (!rx_empty) begin
        pop = 1'b1;
        if (rx_pop_data == CH_CR) begin
          // Bus address/data only change here so they hold steady between commands.
          state_d = S_EXEC;
          if (is_wr_q) begin
            addr_d  = sh_q[15:8];
            wdata_d = sh_q[7:0];
          end else begin
            addr_d = sh_q[7:0];
          end
        end else begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: if (!rx_empty) begin
        pop = 1'b1;
        if (rx_pop_data == CH_CR) state_d = S_ERR;
      end
      S_EXEC: begin
        if (is_wr_q) begin
          resp_load = 1'b1;
          resp_data = make_resp(CH_O, CH_K);
          state_d   = S_RESP;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        resp_load = 1'b1;
        resp_data = make_resp(nib2hex(reg_rdata[7:4]), nib2hex(reg_rdata[3:0]));
        state_d   = S_RESP;
      end
      S_ERR: begin
        resp_load = 1'b1;
        state_d   = S_RESP;
      end
      S_RESP: if (resp_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout: abandon a stalled command silently.
    if (TIMEOUT_CYC != 0 && !pop &&
        (state_q == S_ARG || state_q == S_WAIT_CR || state_q == S_FLUSH)) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_d == TIMEOUT_CYC) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      is_wr_q <= 1'b0;
      nib_q   <= 3'd0;
      sh_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      nib_q   <= nib_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  uart_resp_seq u_resp_seq (
    .clk            (clk),
    .rst            (rst),
    .load_i         (resp_load),
    .load_data_i    (resp_data),
    .tx_full_i      (tx_full),
    .tx_push_o      (tx_push),
    .tx_push_data_o (tx_push_data),
    .done_o         (resp_done)
  );

  // rx_pop is combinational from the FIFO flag, so it is masked while reset is held.
  assign rx_pop    = pop && rst;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = (state_q == S_EXEC) && is_wr_q;
  assign reg_re    = (state_q == S_EXEC) && !is_wr_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_err   = (state_q == S_ERR);

endmodule
